// File: rtl/inv_clarke_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inv_clarke_stage                                           |
// | Description : Inverse Clarke transform stage placed after the rotation   |
// |               CORDIC. A rising edge on done_i captures (alpha, beta),    |
// |               which are turned into three saturated phase references     |
// |               va/vb/vc. The result is held for the PWM stage under a     |
// |               valid/ack handshake.                                       |
// |                                                                          |
// | Ports       : sys_clk_i  clock, rising edge                              |
// |               reset_i    asynchronous active-high reset                  |
// |               done_i     CORDIC done; a rising edge marks a new sample    |
// |               alpha_i    signed alpha (CORDIC x)                          |
// |               beta_i     signed beta  (CORDIC y)                          |
// |               ack_i      PWM stage consumed va/vb/vc                      |
// |               va_o/vb_o/vc_o  signed phase references                    |
// |               valid_o    result valid, held until ack_i                   |
// |               sat_o      sticky: a phase saturated since last ack         |
// |               ovr_o      sticky: unacked result was overwritten           |
// |                                                                          |
// | Option      : ZERO_SEQ_INJ_EN adds min/max zero-sequence injection       |
// |               (two extra stages, latency 3 -> 5 clocks).                 |
// |                                                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module inv_clarke_stage #(
  parameter int DW      = 18,
  parameter int K_SQ3_2 = 113512,
  parameter int KSH     = 17
) (
  input  logic                 sys_clk_i,
  input  logic                 reset_i,
  input  logic                 done_i,
  input  logic signed [DW-1:0] alpha_i,
  input  logic signed [DW-1:0] beta_i,
  input  logic                 ack_i,
  output logic signed [DW-1:0] va_o,
  output logic signed [DW-1:0] vb_o,
  output logic signed [DW-1:0] vc_o,
  output logic                 valid_o,
  output logic                 sat_o,
  output logic                 ovr_o
);

  localparam int PW = 2 * DW;  // product width
  localparam int SW = DW + 2;  // sum width before clamping

  localparam logic signed [PW-1:0] c_k     = PW'(K_SQ3_2);
  localparam logic signed [PW-1:0] c_rnd   = PW'(2 ** (KSH - 1));
  localparam logic signed [SW-1:0] c_max   = SW'((2 ** (DW - 1)) - 1);
  localparam logic signed [SW-1:0] c_min   = -SW'(2 ** (DW - 1));
  localparam logic signed [DW-1:0] c_max_d = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] c_min_d = {1'b1, {(DW-1){1'b0}}};

  function automatic logic signed [DW-1:0] clamp(input logic signed [SW-1:0] x);
    if (x > c_max)      clamp = c_max_d;
    else if (x < c_min) clamp = c_min_d;
    else                clamp = x[DW-1:0];
  endfunction

  function automatic logic out_of_range(input logic signed [SW-1:0] x);
    out_of_range = (x > c_max) || (x < c_min);
  endfunction

  function automatic logic signed [SW-1:0] ext(input logic signed [DW-1:0] x);
    ext = {{2{x[DW-1]}}, x};
  endfunction

  // ---------------------------------------------------------------- strobe
  logic r_done_d;
  logic w_stb;
  assign w_stb = done_i & ~r_done_d;

  // ------------------------------------------------------ S1: beta*sqrt3/2
  logic signed [PW-1:0] w_beta_x;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_prod_sh;
  logic        [DW:0]   w_p_hi;
  logic                 w_p_ovf;
  logic signed [DW-1:0] w_p;

  assign w_beta_x  = {{DW{beta_i[DW-1]}}, beta_i};
  assign w_prod    = w_beta_x * c_k;
  assign w_prod_sh = (w_prod + c_rnd) >>> KSH;

  // With the default constants the scaled product always fits DW bits; the
  // guard only matters if K_SQ3_2/KSH are retuned to a gain above one.
  assign w_p_hi  = w_prod_sh[PW-1:DW-1];
  assign w_p_ovf = !((&w_p_hi) || (~|w_p_hi));
  assign w_p     = w_p_ovf ? (w_prod_sh[PW-1] ? c_min_d : c_max_d)
                           : w_prod_sh[DW-1:0];

  logic                 r_s1_vld;
  logic signed [DW-1:0] r_a;
  logic signed [DW-1:0] r_p;

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_done_d <= 1'b0;
      r_s1_vld <= 1'b0;
      r_a      <= '0;
      r_p      <= '0;
    end else begin
      r_done_d <= done_i;
      r_s1_vld <= w_stb;
      if (w_stb) begin
        r_a <= alpha_i;
        r_p <= w_p;
      end
    end
  end

  // ------------------------------------------------- S2: inverse Clarke
  logic signed [DW-1:0] w_half;
  logic signed [SW-1:0] w_vb_sum;
  logic signed [SW-1:0] w_vc_sum;

  assign w_half   = r_a >>> 1;
  assign w_vb_sum = ext(r_p) - ext(w_half);
  assign w_vc_sum = -ext(w_half) - ext(r_p);

  logic                 r_s2_vld;
  logic                 r_s2_sat;
  logic signed [DW-1:0] r_s2_va;
  logic signed [DW-1:0] r_s2_vb;
  logic signed [DW-1:0] r_s2_vc;

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_s2_vld <= 1'b0;
      r_s2_sat <= 1'b0;
      r_s2_va  <= '0;
      r_s2_vb  <= '0;
      r_s2_vc  <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_va  <= r_a;
        r_s2_vb  <= clamp(w_vb_sum);
        r_s2_vc  <= clamp(w_vc_sum);
        r_s2_sat <= out_of_range(w_vb_sum) | out_of_range(w_vc_sum);
      end
    end
  end

  // Result presented to the output register
  logic                 w_res_vld;
  logic                 w_res_sat;
  logic signed [DW-1:0] w_res_va;
  logic signed [DW-1:0] w_res_vb;
  logic signed [DW-1:0] w_res_vc;

`ifdef ZERO_SEQ_INJ_EN
  // ------------------------------------------------ E1: phase min/max
  logic signed [DW-1:0] w_mx;
  logic signed [DW-1:0] w_mn;

  always_comb begin
    w_mx = r_s2_va;
    w_mn = r_s2_va;
    if (r_s2_vb > w_mx) w_mx = r_s2_vb;
    if (r_s2_vc > w_mx) w_mx = r_s2_vc;
    if (r_s2_vb < w_mn) w_mn = r_s2_vb;
    if (r_s2_vc < w_mn) w_mn = r_s2_vc;
  end

  logic                 r_e1_vld;
  logic                 r_e1_sat;
  logic signed [DW-1:0] r_e1_mx;
  logic signed [DW-1:0] r_e1_mn;
  logic signed [DW-1:0] r_e1_va;
  logic signed [DW-1:0] r_e1_vb;
  logic signed [DW-1:0] r_e1_vc;

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_e1_vld <= 1'b0;
      r_e1_sat <= 1'b0;
      r_e1_mx  <= '0;
      r_e1_mn  <= '0;
      r_e1_va  <= '0;
      r_e1_vb  <= '0;
      r_e1_vc  <= '0;
    end else begin
      r_e1_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_e1_sat <= r_s2_sat;
        r_e1_mx  <= w_mx;
        r_e1_mn  <= w_mn;
        r_e1_va  <= r_s2_va;
        r_e1_vb  <= r_s2_vb;
        r_e1_vc  <= r_s2_vc;
      end
    end
  end

  // ------------------------------------- E2: subtract zero-sequence offset
  logic signed [DW:0]   w_off_sum;
  logic signed [DW:0]   w_off;
  logic signed [SW-1:0] w_off_x;
  logic signed [SW-1:0] w_za;
  logic signed [SW-1:0] w_zb;
  logic signed [SW-1:0] w_zc;

  assign w_off_sum = {r_e1_mx[DW-1], r_e1_mx} + {r_e1_mn[DW-1], r_e1_mn};
  assign w_off     = w_off_sum >>> 1;
  assign w_off_x   = {w_off[DW], w_off};
  assign w_za      = ext(r_e1_va) - w_off_x;
  assign w_zb      = ext(r_e1_vb) - w_off_x;
  assign w_zc      = ext(r_e1_vc) - w_off_x;

  logic                 r_e2_vld;
  logic                 r_e2_sat;
  logic signed [DW-1:0] r_e2_va;
  logic signed [DW-1:0] r_e2_vb;
  logic signed [DW-1:0] r_e2_vc;

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_e2_vld <= 1'b0;
      r_e2_sat <= 1'b0;
      r_e2_va  <= '0;
      r_e2_vb  <= '0;
      r_e2_vc  <= '0;
    end else begin
      r_e2_vld <= r_e1_vld;
      if (r_e1_vld) begin
        r_e2_va  <= clamp(w_za);
        r_e2_vb  <= clamp(w_zb);
        r_e2_vc  <= clamp(w_zc);
        r_e2_sat <= r_e1_sat | out_of_range(w_za) | out_of_range(w_zb)
                  | out_of_range(w_zc);
      end
    end
  end

  assign w_res_vld = r_e2_vld;
  assign w_res_sat = r_e2_sat;
  assign w_res_va  = r_e2_va;
  assign w_res_vb  = r_e2_vb;
  assign w_res_vc  = r_e2_vc;
`else
  assign w_res_vld = r_s2_vld;
  assign w_res_sat = r_s2_sat;
  assign w_res_va  = r_s2_va;
  assign w_res_vb  = r_s2_vb;
  assign w_res_vc  = r_s2_vc;
`endif

  // ------------------------------------------ output register + handshake
  // ack only counts while a result is being presented. A landing result
  // always wins over ack; an overrun is only flagged when the held result
  // was never acknowledged.
  logic w_ack_ok;
  logic w_ovr_set;
  logic w_sat_set;

  assign w_ack_ok  = ack_i & valid_o;
  assign w_ovr_set = w_res_vld & valid_o & ~ack_i;
  assign w_sat_set = w_res_vld & w_res_sat;

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      va_o    <= '0;
      vb_o    <= '0;
      vc_o    <= '0;
      valid_o <= 1'b0;
      sat_o   <= 1'b0;
      ovr_o   <= 1'b0;
    end else begin
      if (w_res_vld) begin
        va_o    <= w_res_va;
        vb_o    <= w_res_vb;
        vc_o    <= w_res_vc;
        valid_o <= 1'b1;
      end else if (w_ack_ok) begin
        valid_o <= 1'b0;
      end

      if (w_sat_set)     sat_o <= 1'b1;
      else if (w_ack_ok) sat_o <= 1'b0;

      if (w_ovr_set)     ovr_o <= 1'b1;
      else if (w_ack_ok) ovr_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire
